// File: rtl/wide_add_pkg.sv
// Shared types and constants for the byte-serial wide adder.
// Combinational helpers only; no latency or backpressure.
// Used by wide_add_seq and its adder slice.
package wide_add_pkg;

   localparam int BYTE_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_e;

   // Byte counter width; one bit minimum so the counter always exists.
   function automatic int cnt_width(input int nbytes);
      return (nbytes < 2) ? 1 : $clog2(nbytes);
   endfunction

endpackage

// File: rtl/adder8_slice.sv
// 8-bit ripple-carry adder slice built from full-adder cells.
// Latency: combinational. Backpressure: none.
// One cell per bit, carry rippling from C0 up to C8.
module adder8_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module adder8_slice
   import wide_add_pkg::*;
(
   output logic [BYTE_W-1:0] S,
   output logic              C8,
   input  logic [BYTE_W-1:0] X,
   input  logic [BYTE_W-1:0] Y,
   input  logic              C0
);
   logic [BYTE_W:0] c;

   assign c[0] = C0;
   assign C8   = c[BYTE_W];

   for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
      adder8_fa u_fa (
         .a  (X[i]),
         .b  (Y[i]),
         .ci (c[i]),
         .s  (S[i]),
         .co (c[i+1])
      );
   end
endmodule

// File: rtl/wide_add_seq.sv
// Byte-serial multi-precision add/subtract over one shared 8-bit adder slice.
// Latency: out_valid rises NBYTES cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; no new accept until back in IDLE.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [BYTE_W*NBYTES-1:0] in_a,
   input  logic [BYTE_W*NBYTES-1:0] in_b,
   input  logic                     in_cin,
   input  logic                     in_sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [BYTE_W*NBYTES-1:0] out_sum,
   output logic                     out_cout,
   output logic                     out_ovf
);
   localparam int CW = cnt_width(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   state_e                            state;
   logic [NBYTES-1:0][BYTE_W-1:0]     a_q;
   logic [NBYTES-1:0][BYTE_W-1:0]     b_q;
   logic [NBYTES-1:0][BYTE_W-1:0]     sum_q;
   logic [CW-1:0]                     cnt;
   logic                              carry_q;
   logic [BYTE_W-1:0]                 slice_s;
   logic                              slice_c8;

   adder8_slice u_slice (
      .S  (slice_s),
      .C8 (slice_c8),
      .X  (a_q[cnt]),
      .Y  (b_q[cnt]),
      .C0 (carry_q)
   );

   assign in_ready = (state == IDLE);
   assign out_sum  = sum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         cnt       <= '0;
         carry_q   <= 1'b0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtract is A + ~B + 1, so B is stored inverted and carry preset.
                  a_q     <= in_a;
                  b_q     <= in_sub ? ~in_b : in_b;
                  carry_q <= in_sub | in_cin;
                  sum_q   <= '0;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_q[cnt] <= slice_s;
               carry_q    <= slice_c8;
               if (cnt == LAST) begin
                  out_cout  <= slice_c8;
                  out_ovf   <= (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                               (slice_s[BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
                  out_valid <= 1'b1;
                  cnt       <= '0;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed plus random bench for wide_add_seq with NBYTES=4.
module tb_wide_add_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        in_cin;
   logic        in_sub;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_sum;
   logic        out_cout;
   logic        out_ovf;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_sum;
   logic        exp_cout;
   logic        exp_ovf;

   wide_add_seq #(.NBYTES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: plain integer arithmetic, signed range check for overflow.
   task automatic model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      longint ua, ub, sa, sb, t, sres;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         t        = ua - ub;
         exp_sum  = t[31:0];
         exp_cout = (ua >= ub);
         sres     = sa - sb;
      end else begin
         t        = ua + ub + longint'(cin);
         exp_sum  = t[31:0];
         exp_cout = (t >= 64'sh1_0000_0000);
         sres     = sa + sb + longint'(cin);
      end
      exp_ovf = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
      @(negedge clk);
      in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
      model(a, b, cin, sub);
      chk("in_ready_idle", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = $urandom; in_b = $urandom;
      in_cin = 1'($urandom); in_sub = 1'($urandom);
   endtask

   task automatic wait_result(input string tag);
      int lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (!out_valid && lat < 4) chk({tag, "_in_ready_run"}, in_ready, 0);
      end while (!out_valid && lat < 20);
      chk({tag, "_latency"}, lat, 4);
      chk({tag, "_sum"}, out_sum, exp_sum);
      chk({tag, "_cout"}, out_cout, exp_cout);
      chk({tag, "_ovf"}, out_ovf, exp_ovf);
   endtask

   task automatic release_out(input string tag);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_sum_hold"}, out_sum, exp_sum);
      chk({tag, "_in_ready_back"}, in_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] na, nb, held_sum;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout", out_cout, 0);
      chk("rst_ovf", out_ovf, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      wait_result("wrap");
      chk("wrap_const_sum", out_sum, 32'h0000_0000);
      chk("wrap_const_cout", out_cout, 1);
      release_out("wrap");

      issue(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
      wait_result("cin");
      chk("cin_const_sum", out_sum, 32'h2345_678A);
      release_out("cin");

      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
      wait_result("sub");
      chk("sub_const_sum", out_sum, 32'hFFFF_FFFE);
      chk("sub_const_cout", out_cout, 0);
      release_out("sub");

      // Backpressure: result held while a new request waits on in_valid.
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      wait_result("ovf");
      chk("ovf_const_sum", out_sum, 32'h8000_0000);
      chk("ovf_const_flag", out_ovf, 1);
      held_sum = exp_sum;
      na = $urandom; nb = $urandom;
      @(negedge clk);
      in_a = na; in_b = nb; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_valid", out_valid, 1);
         chk("bp_sum", out_sum, held_sum);
         chk("bp_in_ready", in_ready, 0);
      end
      release_out("bp");
      model(na, nb, 1'b0, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_result("bp_next");
      release_out("bp_next");

      // Reset mid-RUN after two bytes, then a clean operation.
      issue(32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sum", out_sum, 0);
      chk("mid_rst_cout", out_cout, 0);
      chk("mid_rst_ovf", out_ovf, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      issue(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
      wait_result("post_rst");
      chk("post_rst_const_sum", out_sum, 32'h0000_0030);
      release_out("post_rst");

      for (int i = 0; i < 30; i++) begin
         issue($urandom, $urandom, 1'($urandom), 1'($urandom));
         wait_result("rand");
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            chk("rand_hold_valid", out_valid, 1);
         end
         release_out("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
